// File: rtl/hazard_sequencer.sv
// hazard_sequencer: RAW hazard detection, stall/bubble/flush/freeze control
// and EXE/MEM/WB destination scoreboard feeding the forwarding unit.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   enable_forward        : forwarding on (load-use bubble only) / off (full RAW stall)
//   id_*                  : ID-stage instruction sources, dest and attributes
//   branch_taken          : EXE branch resolved taken
//   mem_ready             : MEM-stage data access completes this cycle
//   stall/bubble/flush/freeze : pipeline register controls
//   exe_dest/mem_dest/wb_dest, mem_wb_en/wb_wb_en : forwarding-unit inputs
//   stall_count           : saturating stall+freeze cycle count (HAZARD_PERF_EN only)
// Build option: define HAZARD_PERF_EN to add the stall_count counter and port.
module hazard_sequencer #(
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_forward,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_use_src1,
   input  logic             id_use_src2,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_wb_en,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             stall,
   output logic             bubble,
   output logic             flush,
   output logic             freeze,
   output logic [REG_W-1:0] exe_dest,
   output logic [REG_W-1:0] mem_dest,
   output logic [REG_W-1:0] wb_dest,
   output logic             mem_wb_en,
   output logic             wb_wb_en
`ifdef HAZARD_PERF_EN
   ,
   output logic [15:0]      stall_count
`endif
);

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest;
      logic             wb_en;
      logic             mem_rd;
      logic             mem_wr;
   } entry_t;

   typedef enum logic {
      IDLE,
      WAIT
   } mem_state_t;

   entry_t           exe_q;
   entry_t           mem_q;
   entry_t           id_e;
   // WB only feeds forwarding, so its memory flags are not kept.
   logic             wb_valid_q;
   logic [REG_W-1:0] wb_dest_q;
   logic             wb_en_q;

   mem_state_t       state_q;
   mem_state_t       state_d;

   logic             hit_exe;
   logic             hit_mem;
   logic             hazard;
   logic             mem_op;
   logic             issue;

   function automatic logic src_hit(
      input entry_t           e,
      input logic             u1,
      input logic [REG_W-1:0] s1,
      input logic             u2,
      input logic [REG_W-1:0] s2
   );
      return e.valid & e.wb_en &
             ((u1 & (s1 == e.dest)) | (u2 & (s2 == e.dest)));
   endfunction

   always_comb begin
      hit_exe = src_hit(exe_q, id_use_src1, id_src1,
                        id_use_src2, id_src2);
      hit_mem = src_hit(mem_q, id_use_src1, id_src1,
                        id_use_src2, id_src2);
      mem_op  = mem_q.valid & (mem_q.mem_rd | mem_q.mem_wr);
      freeze  = mem_op & ~mem_ready;

      // WB never hazards: the regfile writes before it is read.
      hazard = 1'b0;
      if (id_valid) begin
         if (enable_forward)
            hazard = hit_exe & exe_q.mem_rd;
         else
            hazard = hit_exe | hit_mem;
      end

      stall  = 1'b0;
      bubble = 1'b0;
      flush  = 1'b0;
      priority case (1'b1)
         freeze: begin
         end
         branch_taken: begin
            flush = 1'b1;
         end
         default: begin
            stall  = hazard;
            bubble = hazard;
         end
      endcase

      issue = id_valid & ~stall & ~flush;
      id_e  = '0;
      if (issue) begin
         id_e.valid  = 1'b1;
         id_e.dest   = id_dest;
         id_e.wb_en  = id_wb_en;
         id_e.mem_rd = id_mem_read;
         id_e.mem_wr = id_mem_write;
      end
   end

   // WAIT only tracks an outstanding access; freeze does not depend on it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (mem_op & ~mem_ready) state_d = WAIT;
         WAIT: if (mem_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         exe_q      <= '0;
         mem_q      <= '0;
         wb_valid_q <= 1'b0;
         wb_dest_q  <= '0;
         wb_en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (!freeze) begin
            wb_valid_q <= mem_q.valid;
            wb_dest_q  <= mem_q.dest;
            wb_en_q    <= mem_q.wb_en;
            mem_q      <= exe_q;
            exe_q      <= id_e;
         end
      end
   end

   assign exe_dest  = exe_q.dest;
   assign mem_dest  = mem_q.dest;
   assign wb_dest   = wb_dest_q;
   assign mem_wb_en = mem_q.valid & mem_q.wb_en;
   assign wb_wb_en  = wb_valid_q & wb_en_q;

`ifdef HAZARD_PERF_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if ((stall | freeze) && (cnt_q != 16'hFFFF))
         cnt_q <= cnt_q + 16'd1;
   end

   assign stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed scenarios plus randomized traffic
// against a stage-array reference model of the hazard sequencer.
module tb_hazard_sequencer;
   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         enable_forward;
   logic         id_valid;
   logic [W-1:0] id_src1, id_src2, id_dest;
   logic         id_use_src1, id_use_src2;
   logic         id_wb_en, id_mem_read, id_mem_write;
   logic         branch_taken, mem_ready;
   logic         stall, bubble, flush, freeze;
   logic [W-1:0] exe_dest, mem_dest, wb_dest;
   logic         mem_wb_en, wb_wb_en;
`ifdef HAZARD_PERF_EN
   logic [15:0]  stall_count;
   int           m_cnt = 0;
`endif

   int total = 0;
   int bad   = 0;

   // model: index 0=EXE, 1=MEM, 2=WB
   logic         m_v[3];
   logic [W-1:0] m_d[3];
   logic         m_w[3];
   logic         m_r[3];
   logic         m_x[3];

   always #5 clk = ~clk;

   hazard_sequencer #(.REG_W(W)) dut (
      .clk(clk), .rst(rst), .enable_forward(enable_forward),
      .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
      .id_dest(id_dest), .id_wb_en(id_wb_en),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .branch_taken(branch_taken), .mem_ready(mem_ready),
      .stall(stall), .bubble(bubble), .flush(flush), .freeze(freeze),
      .exe_dest(exe_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
      .mem_wb_en(mem_wb_en), .wb_wb_en(wb_wb_en)
`ifdef HAZARD_PERF_EN
      , .stall_count(stall_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic hit(int k);
      return m_v[k] && m_w[k] &&
             ((id_use_src1 && id_src1 == m_d[k]) ||
              (id_use_src2 && id_src2 == m_d[k]));
   endfunction

   function automatic logic e_freeze();
      return m_v[1] && (m_r[1] || m_x[1]) && !mem_ready;
   endfunction

   function automatic logic e_hazard();
      if (!id_valid) return 1'b0;
      if (enable_forward) return hit(0) && m_r[0];
      return hit(0) || hit(1);
   endfunction

   function automatic logic e_stall();
      return !e_freeze() && !branch_taken && e_hazard();
   endfunction

   function automatic logic e_flush();
      return !e_freeze() && branch_taken;
   endfunction

   task automatic check_all();
      chk("freeze", freeze, e_freeze());
      chk("flush", flush, e_flush());
      chk("stall", stall, e_stall());
      chk("bubble", bubble, e_stall());
      chk("exe_dest", exe_dest, m_d[0]);
      chk("mem_dest", mem_dest, m_d[1]);
      chk("wb_dest", wb_dest, m_d[2]);
      chk("mem_wb_en", mem_wb_en, m_v[1] && m_w[1]);
      chk("wb_wb_en", wb_wb_en, m_v[2] && m_w[2]);
`ifdef HAZARD_PERF_EN
      chk("stall_count", stall_count, m_cnt);
`endif
   endtask

   task automatic model_clear();
      for (int k = 0; k < 3; k++) begin
         m_v[k] = 0; m_d[k] = '0; m_w[k] = 0; m_r[k] = 0; m_x[k] = 0;
      end
   endtask

   task automatic tick();
      logic fz, st, fl, iss;
      fz  = e_freeze();
      st  = e_stall();
      fl  = e_flush();
      iss = id_valid && !st && !fl;
      @(posedge clk);
      if (rst) begin
         model_clear();
`ifdef HAZARD_PERF_EN
         m_cnt = 0;
`endif
      end else begin
`ifdef HAZARD_PERF_EN
         if ((st || fz) && m_cnt < 65535) m_cnt++;
`endif
         if (!fz) begin
            for (int k = 2; k > 0; k--) begin
               m_v[k] = m_v[k-1]; m_d[k] = m_d[k-1]; m_w[k] = m_w[k-1];
               m_r[k] = m_r[k-1]; m_x[k] = m_x[k-1];
            end
            m_v[0] = iss;
            m_d[0] = iss ? id_dest : '0;
            m_w[0] = iss && id_wb_en;
            m_r[0] = iss && id_mem_read;
            m_x[0] = iss && id_mem_write;
         end
      end
      #1;
   endtask

   task automatic set_id(input logic v, input int s1, input logic u1,
                         input int s2, input logic u2, input int d,
                         input logic wb, input logic mr, input logic mw);
      id_valid = v;
      id_src1 = W'(s1); id_use_src1 = u1;
      id_src2 = W'(s2); id_use_src2 = u2;
      id_dest = W'(d);  id_wb_en = wb;
      id_mem_read = mr; id_mem_write = mw;
   endtask

   task automatic idle(input int n);
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      branch_taken = 0;
      for (int i = 0; i < n; i++) begin
         #1; check_all(); tick();
      end
   endtask

   initial begin
      int n;
      model_clear();
      rst = 1; enable_forward = 1; branch_taken = 0; mem_ready = 1;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      rst = 0;
      #1; check_all();
      chk("rst_stall", stall, 0);
      chk("rst_freeze", freeze, 0);
      chk("rst_exe_dest", exe_dest, 0);
      chk("rst_wb_wb_en", wb_wb_en, 0);

      // load-use with forwarding
      set_id(1, 0, 0, 0, 0, 3, 1, 1, 0);
      #1; check_all(); tick();
      set_id(1, 3, 1, 1, 0, 4, 1, 0, 0);
      #1; check_all();
      chk("lu_stall", stall, 1);
      chk("lu_bubble", bubble, 1);
      tick();
      #1; check_all();
      chk("lu_stall_end", stall, 0);
      chk("lu_mem_dest", mem_dest, 3);
      chk("lu_mem_wb_en", mem_wb_en, 1);
      tick();
      idle(3);

      // RAW without forwarding, adjacent producer
      enable_forward = 0;
      set_id(1, 0, 0, 0, 0, 5, 1, 0, 0);
      #1; check_all(); tick();
      set_id(1, 5, 1, 2, 1, 6, 1, 0, 0);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         #1; check_all();
         if (!stall) break;
         n++; tick();
      end
      chk("raw_adj_cycles", n, 2);
      chk("raw_wb_dest", wb_dest, 5);
      tick();

      // RAW without forwarding, one instruction between
      set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
      #1; check_all(); tick();
      set_id(1, 1, 1, 2, 1, 8, 1, 0, 0);
      #1; check_all(); tick();
      set_id(1, 0, 1, 7, 1, 9, 1, 0, 0);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         #1; check_all();
         if (!stall) break;
         n++; tick();
      end
      chk("raw_gap_cycles", n, 1);
      tick();
      idle(3);

      // branch beats a load-use hazard
      enable_forward = 1;
      set_id(1, 0, 0, 0, 0, 7, 1, 1, 0);
      #1; check_all(); tick();
      set_id(1, 7, 1, 0, 0, 10, 1, 0, 0);
      branch_taken = 1;
      #1; check_all();
      chk("br_flush", flush, 1);
      chk("br_stall", stall, 0);
      chk("br_bubble", bubble, 0);
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      branch_taken = 0;
      #1; check_all();
      chk("br_exe_dest", exe_dest, 0);
      tick();
      #1; check_all();
      chk("br_mem_wb_en", mem_wb_en, 0);
      idle(3);

      // memory wait with branch held during freeze
      set_id(1, 0, 0, 0, 0, 9, 1, 1, 0);
      #1; check_all(); tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      mem_ready = 0;
      #1; check_all(); tick();
      branch_taken = 1;
      for (int i = 0; i < 3; i++) begin
         #1; check_all();
         chk("mw_freeze", freeze, 1);
         chk("mw_flush", flush, 0);
         chk("mw_mem_dest", mem_dest, 9);
         tick();
      end
      mem_ready = 1;
      branch_taken = 0;
      #1; check_all();
      chk("mw_release", freeze, 0);
      tick();
      #1; check_all();
      chk("mw_wb_dest", wb_dest, 9);
      idle(3);

      // reset while frozen
      set_id(1, 0, 0, 0, 0, 2, 1, 1, 0);
      #1; check_all(); tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1; check_all(); tick();
      mem_ready = 0;
      #1; check_all();
      chk("rr_frozen", freeze, 1);
      rst = 1;
      tick();
      rst = 0;
      #1; check_all();
      chk("rr_freeze", freeze, 0);
      chk("rr_mem_dest", mem_dest, 0);
      chk("rr_mem_wb_en", mem_wb_en, 0);
`ifdef HAZARD_PERF_EN
      chk("rr_stall_count", stall_count, 0);
`endif
      mem_ready = 1;
      idle(2);

      // unused source must not stall
      enable_forward = 0;
      set_id(1, 0, 0, 0, 0, 8, 1, 0, 0);
      #1; check_all(); tick();
      set_id(1, 1, 1, 8, 0, 11, 1, 0, 0);
      #1; check_all();
      chk("unused_stall", stall, 0);
      tick();
      idle(3);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         enable_forward = 1'($urandom_range(0, 1));
         set_id(1'($urandom_range(0, 1)),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         mem_ready = ($urandom_range(0, 3) != 0);
         branch_taken = ($urandom_range(0, 7) == 0);
         #1; check_all();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
